// File: rtl/alu_result_stage.sv
// Registered ALU datapath and result stage with valid/ready handoff to writeback.
// Define ALU_RESULT_SKID_EN for a 2-entry (output + skid) buffer with registered in_ready.
module alu_result_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN:0]    in_a,
  input  logic [XLEN:0]    in_b,
  input  logic [4:0]       alu_op,
  input  logic [4:0]       in_rd,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLT  = 5'd2,
    OP_SLTU = 5'd3,
    OP_XOR  = 5'd4,
    OP_OR   = 5'd5,
    OP_AND  = 5'd6,
    OP_LUI  = 5'd7
  } alu_op_e;

  typedef struct packed {
    logic            illegal;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } entry_t;

  entry_t          new_e;
  logic [XLEN-1:0] sum_lo;
  logic [XLEN:0]   diff;
  logic            slt;

  // Only the low XLEN bits of the sum survive, so the add is done at XLEN width.
  always_comb begin
    sum_lo = in_a[XLEN-1:0] + in_b[XLEN-1:0];
    diff   = in_a - in_b;
    slt    = $signed(in_a[XLEN-1:0]) < $signed(in_b[XLEN-1:0]);
    new_e  = '0;
    new_e.rd = in_rd;
    case (alu_op_e'(alu_op))
      OP_ADD:  new_e.result = sum_lo;
      OP_SUB:  new_e.result = diff[XLEN-1:0];
      OP_SLT:  new_e.result = {{(XLEN-1){1'b0}}, slt};
      OP_SLTU: new_e.result = {{(XLEN-1){1'b0}}, diff[XLEN]};
      OP_XOR:  new_e.result = in_a[XLEN-1:0] ^ in_b[XLEN-1:0];
      OP_OR:   new_e.result = in_a[XLEN-1:0] | in_b[XLEN-1:0];
      OP_AND:  new_e.result = in_a[XLEN-1:0] & in_b[XLEN-1:0];
      OP_LUI:  new_e.result = in_b[XLEN-1:0];
      default: new_e.illegal = 1'b1;
    endcase
  end

  logic             out_valid_q, out_valid_d;
  entry_t           out_e_q, out_e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             retire;

  assign retire = out_valid_q & out_ready;
  assign cnt_d  = retire ? cnt_q + 1'b1 : cnt_q;

`ifdef ALU_RESULT_SKID_EN
  logic   skid_valid_q, skid_valid_d;
  entry_t skid_e_q, skid_e_d;
  logic   in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign accept   = in_valid & in_ready_q;

  // in_ready_q mirrors skid emptiness, so an accept never coincides with a full skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_e_d      = out_e_q;
    skid_valid_d = skid_valid_q;
    skid_e_d     = skid_e_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (retire) begin
        out_e_d      = skid_e_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || retire) begin
        out_valid_d = 1'b1;
        out_e_d     = new_e;
      end else begin
        skid_valid_d = 1'b1;
        skid_e_d     = new_e;
      end
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_e_q     <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_e_q     <= skid_e_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_e_d     = out_e_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_e_d     = new_e;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_e_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_e_q     <= out_e_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_e_q.result;
  assign out_rd      = out_e_q.rd;
  assign out_illegal = out_e_q.illegal;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; retired_cnt is narrowed to 4 bits so it wraps during the run.
module tb_alu_result_stage;

`ifdef ALU_RESULT_SKID_EN
  localparam int HELD = 2;
`else
  localparam int HELD = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] in_a, in_b;
  logic [4:0]  alu_op, in_rd;
  logic        in_valid, in_ready, flush;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [3:0]  retired_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_cnt;

  always #5 clk = ~clk;

  alu_result_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .in_rd(in_rd),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    alu_op   = op;
    in_a     = {1'b0, a};
    in_b     = {1'b0, b};
    in_rd    = rd;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; alu_op = '0; in_rd = '0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", out_result); end
    n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", out_rd); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", retired_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
    exp_cnt = 4'd0;
  endtask

  task automatic test_alu_ops();
    vec_t v[12];
    logic [3:0] e;
    v[0]  = '{5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    v[1]  = '{5'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    v[2]  = '{5'd3, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0};
    v[3]  = '{5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    v[4]  = '{5'd2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    v[5]  = '{5'd7, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0};
    v[6]  = '{5'd9, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1};
    v[7]  = '{5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    v[8]  = '{5'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    v[9]  = '{5'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    v[10] = '{5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    v[11] = '{5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_op(v[i].op, v[i].a, v[i].b, 5'(i + 1));
      tick();
      e = exp_cnt + 4'(i);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_result !== v[i].res) begin n_fail++; $display("FAIL alu_result[%0d]: got %h want %h", i, out_result, v[i].res); end
      n_checks++; if (out_rd !== 5'(i + 1)) begin n_fail++; $display("FAIL alu_rd[%0d]: got %0d want %0d", i, out_rd, i + 1); end
      n_checks++; if (out_illegal !== v[i].ill) begin n_fail++; $display("FAIL alu_illegal[%0d]: got %b want %b", i, out_illegal, v[i].ill); end
      n_checks++; if (retired_cnt !== e) begin n_fail++; $display("FAIL alu_cnt[%0d]: got %0d want %0d", i, retired_cnt, e); end
    end
    in_valid = 1'b0;
    tick();
    exp_cnt = exp_cnt + 4'd12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL alu_drain_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [4:0]  ops[3];
    logic [31:0] as[3], bs[3], rs[3];
    int idx, held, got;
    logic acc, exp_rdy;
    ops = '{5'd0, 5'd1, 5'd4};
    as  = '{32'd1, 32'd10, 32'h000000FF};
    bs  = '{32'd2, 32'd3, 32'h0000000F};
    rs  = '{32'd3, 32'd7, 32'h000000F0};
    idx = 0; held = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) drive_op(ops[idx], as[idx], bs[idx], 5'(10 + idx));
      else in_valid = 1'b0;
      #1;
      exp_rdy = (held < HELD);
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
      tick();
      if (exp_rdy) begin idx++; held++; end
      n_checks++; if (out_valid !== 1'b1 || out_result !== rs[0] || out_rd !== 5'd10)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b r=%h rd=%0d want v=1 r=%h rd=10", c, out_valid, out_result, out_rd, rs[0]); end
    end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (idx < 3) drive_op(ops[idx], as[idx], bs[idx], 5'(10 + idx));
      else in_valid = 1'b0;
      #1;
      acc = in_valid & in_ready;
      if (out_valid === 1'b1) begin
        n_checks++; if (out_result !== rs[got] || out_rd !== 5'(10 + got))
          begin n_fail++; $display("FAIL stall_order[%0d]: got r=%h rd=%0d want r=%h rd=%0d", got, out_result, out_rd, rs[got], 10 + got); end
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 4'd3;
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL stall_emerged: got %0d want 3", got); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(5'd0, 32'(i * 3), 32'd100, 5'(i));
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      e = exp_cnt + 4'(i);
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'(i * 3 + 100) || out_rd !== 5'(i))
        begin n_fail++; $display("FAIL b2b_out[%0d]: got v=%b r=%0d rd=%0d want v=1 r=%0d rd=%0d", i, out_valid, out_result, out_rd, i * 3 + 100, i); end
      n_checks++; if (retired_cnt !== e) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, retired_cnt, e); end
    end
    in_valid = 1'b0;
    tick();
    exp_cnt = exp_cnt + 4'd10;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %b want 0", out_valid); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt_wrap: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(5'd0, 32'd1, 32'd1, 5'd20); tick();
    drive_op(5'd0, 32'd2, 32'd2, 5'd21); tick();
    drive_op(5'd0, 32'd3, 32'd3, 5'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_none[%0d]: got %b want 0", c, out_valid); end
    end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    drive_op(5'd5, 32'h0000F000, 32'h0000000F, 5'd23); tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_retire_valid: got %b want 0", out_valid); end
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_retire_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
    drive_op(5'd0, 32'd5, 32'd6, 5'd7); tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_result !== 32'd11 || out_rd !== 5'd7)
      begin n_fail++; $display("FAIL flush_recover: got v=%b r=%0d rd=%0d want v=1 r=11 rd=7", out_valid, out_result, out_rd); end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_final_cnt: got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_stall();
    test_back_to_back();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
